// File: rtl/rams_tdp_be_init.sv
// True-dual-port RAM with per-byte write enables, optional output register, port-A-wins
// write arbitration and a zero-fill sweep that runs after every reset.
module rams_tdp_be_init #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned BYTE_WIDTH = 8,
  parameter int unsigned OUT_REG    = 0,
  parameter int unsigned INIT_ZERO  = 1,
  parameter int unsigned ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int unsigned NB_BYTES   = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic                  init_done_o,
  input  logic                  ena_i,
  input  logic                  enb_i,
  input  logic [NB_BYTES-1:0]   wea_i,
  input  logic [NB_BYTES-1:0]   web_i,
  input  logic [ADDR_WIDTH-1:0] addra_i,
  input  logic [ADDR_WIDTH-1:0] addrb_i,
  input  logic [DATA_WIDTH-1:0] dina_i,
  input  logic [DATA_WIDTH-1:0] dinb_i,
  output logic [DATA_WIDTH-1:0] douta_o,
  output logic [DATA_WIDTH-1:0] doutb_o,
  output logic                  douta_valid_o,
  output logic                  doutb_valid_o,
  output logic                  collision_o
);

  typedef enum logic [0:0] {StInit, StReady} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    ready, sweep_we;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StInit: begin
        if (INIT_ZERO == 0 || cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
          state_d = StReady;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      StReady: state_d = StReady;
      default: state_d = StInit;
    endcase
  end

  always_comb begin
    ready       = (state_q == StReady);
    sweep_we    = (state_q == StInit) && (INIT_ZERO != 0);
    init_done_o = ready;
  end

  logic                  acc_a, acc_b, in_a, in_b;
  logic [NB_BYTES-1:0]   wr_a, wr_b;
  logic [DATA_WIDTH-1:0] rd_a, rd_b;

  always_comb begin
    acc_a = ready & ena_i;
    acc_b = ready & enb_i;
    in_a  = 32'(addra_i) < DEPTH;
    in_b  = 32'(addrb_i) < DEPTH;
    wr_a  = {NB_BYTES{acc_a & in_a}} & wea_i;
    wr_b  = {NB_BYTES{acc_b & in_b}} & web_i;
    rd_a  = in_a ? mem_q[addra_i] : '0;
    rd_b  = in_b ? mem_q[addrb_i] : '0;
  end

  // Port A bytes are assigned last so they win when both ports hit the same byte.
  always_ff @(posedge clk_i) begin
    if (sweep_we) begin
      mem_q[cnt_q] <= '0;
    end
    for (int i = 0; i < NB_BYTES; i++) begin
      if (wr_b[i]) mem_q[addrb_i][i*BYTE_WIDTH +: BYTE_WIDTH] <= dinb_i[i*BYTE_WIDTH +: BYTE_WIDTH];
      if (wr_a[i]) mem_q[addra_i][i*BYTE_WIDTH +: BYTE_WIDTH] <= dina_i[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  logic                  va1_q, vb1_q, coll_q, coll_d;
  logic [DATA_WIDTH-1:0] da1_q, db1_q, da1_d, db1_d;

  always_comb begin
    da1_d  = acc_a ? rd_a : da1_q;
    db1_d  = acc_b ? rd_b : db1_q;
    coll_d = acc_a & acc_b & in_a & (addra_i == addrb_i) & (|(wea_i & web_i));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      va1_q  <= 1'b0;
      vb1_q  <= 1'b0;
      da1_q  <= '0;
      db1_q  <= '0;
      coll_q <= 1'b0;
    end else begin
      va1_q  <= acc_a;
      vb1_q  <= acc_b;
      da1_q  <= da1_d;
      db1_q  <= db1_d;
      coll_q <= coll_d;
    end
  end

  assign collision_o = coll_q;

  if (OUT_REG != 0) begin : g_out_reg
    logic                  va2_q, vb2_q;
    logic [DATA_WIDTH-1:0] da2_q, db2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        va2_q <= 1'b0;
        vb2_q <= 1'b0;
        da2_q <= '0;
        db2_q <= '0;
      end else begin
        va2_q <= va1_q;
        vb2_q <= vb1_q;
        if (va1_q) da2_q <= da1_q;
        if (vb1_q) db2_q <= db1_q;
      end
    end

    assign douta_o       = da2_q;
    assign doutb_o       = db2_q;
    assign douta_valid_o = va2_q;
    assign doutb_valid_o = vb2_q;
  end else begin : g_no_out_reg
    assign douta_o       = da1_q;
    assign doutb_o       = db1_q;
    assign douta_valid_o = va1_q;
    assign doutb_valid_o = vb1_q;
  end

endmodule
